// File: rtl/div_iter.sv
// ----------------------------------------------------------------------------
// div_iter -- iterative restoring radix-2 divider for DIV / DIVU.
//
// The divider takes the rs and rt operands and returns the quotient (to LO)
// and the remainder (to HI). It resolves one quotient bit per clock on
// operand magnitudes, then applies the sign fix-up in a final cycle. From the
// edge that accepts start to the cycle where done is high takes 33 clocks.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous reset, active-high
//   start      request a division; accepted only while busy=0
//   is_signed  1 = DIV (two's complement), 0 = DIVU; sampled with start
//   dividend   rs value; sampled with start
//   divisor    rt value; sampled with start
//   quotient   registered quotient (LO)
//   remainder  registered remainder (HI)
//   busy       high while a division is in progress
//   done       one-cycle pulse when quotient/remainder become valid
//   div_zero   the divisor of the last completed operation was 0
// ----------------------------------------------------------------------------
module div_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX
  } state_t;

  state_t state, state_next;

  logic             op_signed;  // latched is_signed
  logic             neg_dvd;    // dividend was negative (signed op only)
  logic             neg_dvs;    // divisor was negative (signed op only)
  logic [WIDTH-1:0] mag_dvs;    // |divisor|
  logic [WIDTH-1:0] rem;        // partial remainder
  logic [WIDTH-1:0] quo;        // dividend bits shifting out, quotient bits shifting in
  logic [CW-1:0]    count;

  // Operand magnitudes at acceptance. An unsigned 32-bit magnitude keeps
  // |0x80000000| exact, so the signed overflow case needs no special path.
  logic             in_neg_dvd, in_neg_dvs;
  logic [WIDTH-1:0] in_mag_dvd, in_mag_dvs;

  assign in_neg_dvd = is_signed & dividend[WIDTH-1];
  assign in_neg_dvs = is_signed & divisor[WIDTH-1];
  assign in_mag_dvd = in_neg_dvd ? -dividend : dividend;
  assign in_mag_dvs = in_neg_dvs ? -divisor  : divisor;

  // One restoring step: shift {rem,quo} left and trial-subtract over
  // WIDTH+1 bits. When rem_sh has its top bit set it already exceeds any
  // divisor and the difference fits in WIDTH bits, so trial[WIDTH] is a
  // reliable borrow flag in every case.
  logic [WIDTH:0] rem_sh, trial;
  logic           trial_ok;

  assign rem_sh   = {rem, quo[WIDTH-1]};
  assign trial    = rem_sh - {1'b0, mag_dvs};
  assign trial_ok = ~trial[WIDTH];

  // Truncating-division sign fix-up: the quotient is negative when the
  // operand signs differ, and the remainder takes the sign of the dividend.
  logic [WIDTH-1:0] fix_quo, fix_rem;

  assign fix_quo = (op_signed & (neg_dvd ^ neg_dvs)) ? -quo : quo;
  assign fix_rem = (op_signed & neg_dvd) ? -rem : rem;

  assign busy = (state != IDLE);

  // NOTE: state and datapath registers use non-blocking assignments so every
  // flop samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // NOTE: state_next gets its default before the case so no path through the
  // block leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (start) state_next = CALC;
      CALC:    if (count == CW'(WIDTH - 1)) state_next = FIX;
      FIX:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_signed <= 1'b0;
      neg_dvd   <= 1'b0;
      neg_dvs   <= 1'b0;
      mag_dvs   <= '0;
      rem       <= '0;
      quo       <= '0;
      count     <= '0;
      quotient  <= '0;
      remainder <= '0;
      done      <= 1'b0;
      div_zero  <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            op_signed <= is_signed;
            neg_dvd   <= in_neg_dvd;
            neg_dvs   <= in_neg_dvs;
            mag_dvs   <= in_mag_dvs;
            rem       <= '0;
            quo       <= in_mag_dvd;
            count     <= '0;
          end
        end
        CALC: begin
          rem   <= trial_ok ? trial[WIDTH-1:0] : rem_sh[WIDTH-1:0];
          quo   <= {quo[WIDTH-2:0], trial_ok};
          count <= count + 1'b1;
        end
        FIX: begin
          quotient  <= fix_quo;
          remainder <= fix_rem;
          div_zero  <= (mag_dvs == '0);
          done      <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/div_iter.md
Name: div_iter

Overview:
- Iterative 32-bit divider for DIV/DIVU, sitting directly downstream of the register file read ports.
- Consumes rs (dividend) and rt (divisor) operand values and produces the quotient/remainder pair destined for LO/HI.
- A restoring radix-2 engine resolves one quotient bit per clock.
- Start/busy/done handshake with the multicycle control unit, which holds the instruction in its execute state until done.

Parameters:
- WIDTH, 32, operand and result width; all values below assume 32.

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  synchronous reset, active-high
- start  input  1  request a division; accepted only when busy=0
- is_signed  input  1  1=DIV (two's complement), 0=DIVU; sampled with start
- dividend  input  32  rs value; sampled with start
- divisor  input  32  rt value; sampled with start
- quotient  output  32  result to LO; registered
- remainder  output  32  result to HI; registered
- busy  output  1  high while a division is in progress
- done  output  1  one-cycle pulse when quotient/remainder become valid
- div_zero  output  1  divisor was 0 for the last completed operation; valid with done, held until next completion

Behaviour:
- Reset: rst=1 at a rising edge forces:
  - state IDLE; quotient=0, remainder=0, busy=0, done=0, div_zero=0; internal counters and registers 0.
  - Reset has priority over every other input, including mid-operation; an aborted division produces no done.
- States: IDLE, CALC, FIX.
- IDLE:
  - start=1 at edge E0: latch is_signed, sign(dividend), sign(divisor), and the magnitudes |dividend|, |divisor| (magnitude = raw value when unsigned; two's-complement negation when signed and negative); clear partial remainder; count=0; busy=1; go to CALC.
  - start=0: stay in IDLE.
- CALC, edges E1..E32, one iteration per edge:
  - Shift {rem,quo} left 1.
  - Trial subtract: rem - |divisor| over 33 bits.
  - Non-negative: keep the difference and set quo[0]=1; otherwise restore and set quo[0]=0.
  - count increments; after the 32nd iteration go to FIX.
- FIX, edge E33:
  - Quotient negated iff signed and the operand signs differ.
  - Remainder negated iff signed and the dividend was negative.
  - Write quotient/remainder outputs; div_zero = (latched divisor==0); done=1 for exactly the cycle after E33; busy=0 after E33; go to IDLE.
- Latency: done is visible 33 clocks after the accepting edge. Outputs hold until the next FIX.
- busy is high from after E0 through the cycle ending at E33.
- start while busy=1 is ignored (not queued), and latched operands are unaffected.
- start in the done cycle is accepted (busy=0) → back-to-back operations with no idle gap.
- Divide by zero is not trapped and runs the full latency. Result is fixed by the algorithm: quotient=0xFFFFFFFF before sign fix. Required final values:
  - DIVU x/0 → q=0xFFFFFFFF, r=x.
  - DIV x/0 → q=0xFFFFFFFF if x≥0, else 0x00000001; r=x.
- Signed overflow 0x80000000/0xFFFFFFFF → q=0x80000000, r=0. The magnitude path is 32-bit unsigned, so |0x80000000| = 0x80000000 is exact.
- Remainder sign always follows the dividend (truncating division); |r| < |divisor| whenever divisor≠0.
- Operand inputs may change freely after E0.

Test Plan:
- DIVU 100/7: start for one cycle → done exactly 33 clocks later with q=14 (0x0000000E), r=2, div_zero=0; busy high for 33 cycles.
- DIV 0xFFFFFFF9 (-7) / 2 → q=0xFFFFFFFD (-3), r=0xFFFFFFFF (-1). DIV 7/0xFFFFFFFE (-2) → q=0xFFFFFFFD, r=1.
- DIV 0x80000000/0xFFFFFFFF → q=0x80000000, r=0. DIVU 0xFFFFFFFF/1 → q=0xFFFFFFFF, r=0.
- DIVU 5/0 → q=0xFFFFFFFF, r=5, div_zero=1. Following DIVU 9/3 → q=3, r=0, div_zero=0.
- Start DIVU 100/7, pulse start again with 50/5 at cycle 5 → ignored, result q=14, r=2. Issue 50/5 in the done cycle → accepted, second done 33 clocks later with q=10, r=0.
- Start DIV 1000/3, assert rst at cycle 10 → next cycle busy=0, done=0, q=0, r=0; no done within 40 cycles. New start after reset completes normally.
